// File: rtl/tff_toggle_seq.sv
// Toggle sequencer for a single T flip-flop: issues N single-cycle t pulses spaced by a gap and verifies q.
// Optional q checking is enabled by defining TFF_TOGGLE_SEQ_QCHK_EN; otherwise err stays 0.
module tff_toggle_seq #(
  parameter int CNT_W = 8,
  parameter int IVL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_toggles,
  input  logic [IVL_W-1:0] interval,
  input  logic             abort,
  output logic             t,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] toggles_done
);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_PULSE, S_CHECK, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IVL_W-1:0] ivl_q, ivl_d;
  logic [IVL_W-1:0] gap_q, gap_d;
  logic             qexp_q, qexp_d;
  logic             err_q, err_d;
  logic             t_q, busy_q, done_q;
  logic             q_hit;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
`ifdef TFF_TOGGLE_SEQ_QCHK_EN
    q_hit = (q == qexp_q);
`else
    q_hit = 1'b1;
`endif
    cnt_inc = cnt_q + 1'b1;
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    ivl_d   = ivl_q;
    gap_d   = gap_q;
    qexp_d  = qexp_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d  = num_toggles;
          ivl_d  = interval;
          gap_d  = interval;
          qexp_d = ~q;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (num_toggles == '0)   state_d = S_DONE;
          else if (interval == '0) state_d = S_PULSE;
          else                     state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (abort)                     state_d = S_DONE;
        else if (gap_q == IVL_W'(1))   state_d = S_PULSE;
      end
      S_PULSE: state_d = S_CHECK;
      S_CHECK: begin
        if (!q_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d  = cnt_inc;
          qexp_d = ~qexp_q;
          // Final count and abort in the same cycle both land in one DONE.
          if (cnt_inc == num_q || abort) state_d = S_DONE;
          else if (ivl_q == '0)          state_d = S_PULSE;
          else begin
            state_d = S_GAP;
            gap_d   = ivl_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      ivl_q   <= '0;
      gap_q   <= '0;
      qexp_q  <= 1'b0;
      err_q   <= 1'b0;
      t_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      ivl_q   <= ivl_d;
      gap_q   <= gap_d;
      qexp_q  <= qexp_d;
      err_q   <= err_d;
      // Outputs are registered from the next state so they line up with the state they decode.
      t_q     <= (state_d == S_PULSE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign t            = t_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign toggles_done = cnt_q;

endmodule

// File: doc/tff_toggle_seq.md
Name: tff_toggle_seq

Overview:
- Sequencer for the single-bit T flip-flop datapath (t in, q out).
- Takes a command of N toggles spaced by a programmable gap, drives the flop's t input as single-cycle pulses, and checks q after every pulse.
- Reports busy/done/err to the upstream test or control logic; sits between that logic and the tff instance.

Parameters:
- CNT_W, 8, width of num_toggles and toggles_done.
- IVL_W, 8, width of interval (idle cycles before each pulse).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- num_toggles  in  CNT_W  toggles to issue; latched on accepted start.
- interval  in  IVL_W  gap cycles before each pulse; latched on accepted start.
- abort  in  1  stop request; sampled only in GAP and CHECK.
- t  out  1  drives tff.t; registered.
- q  in  1  feedback from tff.q.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse in DONE.
- err  out  1  sticky toggle-mismatch flag; cleared on the next accepted start.
- toggles_done  out  CNT_W  count of verified toggles in the current or last command.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; t, busy, done, err = 0; toggles_done = 0; internal counters and latches = 0.
- State encoding: IDLE, GAP, PULSE, CHECK, DONE. Outputs are registered or decoded from state only, with no combinational path from inputs.
- IDLE:
  - start=1 latches num_toggles and interval, captures q_exp = ~q, clears err and toggles_done.
  - num_toggles=0 -> DONE. interval=0 -> PULSE. Otherwise GAP with gap counter = interval.
  - start while busy is ignored; it is not queued.
- GAP: counter decrements each cycle, so GAP lasts exactly interval cycles, then PULSE. abort=1 -> DONE; no further pulse.
- PULSE: t=1 for exactly one cycle, then CHECK. abort is not sampled here.
- CHECK:
  - t=0. q reflects the flop update from the end of PULSE.
  - q == q_exp: toggles_done+1, q_exp inverts.
  - q != q_exp: err=1 -> DONE.
  - Without error: -> DONE if the new toggles_done == num_toggles or abort=1. Else -> PULSE if interval=0, otherwise -> GAP (reload counter).
- DONE: done=1 for one cycle, busy=1, then IDLE (busy=0 next cycle).
- Timing:
  - start accepted in cycle 0 -> first t=1 in cycle 1+interval.
  - Each toggle costs interval+2 cycles.
  - Clean run: done in cycle N*(interval+2)+1. N=0: done in cycle 1.
- Boundaries:
  - num_toggles = 2^CNT_W-1 is supported; toggles_done never wraps within a command.
  - interval=0 gives back-to-back PULSE/CHECK, so t has a 50% duty cycle.
  - abort and final-count in the same CHECK cycle -> single DONE, no err.
  - rst asserted mid-run forces t=0 immediately and returns to IDLE. toggles_done is lost.

Optional Feature:
- Macro TFF_TOGGLE_SEQ_QCHK_EN.
- Defined: q compare in CHECK as above; err can assert.
- Undefined: q is ignored, err tied 0, every CHECK counts the toggle. State sequence and cycle timing are identical.

Test Plan:
- rst low 20 ns then high; start, N=3, interval=0 -> t pulses in cycles 1, 3, 5; q goes 0->1->0->1; done in cycle 7; toggles_done=3; err=0.
- start, N=2, interval=3 -> t high in cycles 4 and 9; done in cycle 11; busy high in cycles 1-11.
- start, N=0 -> no t pulse; done in cycle 1; toggles_done=0.
- Force q stuck at 0 after the first pulse (QCHK_EN defined), N=4 -> err=1 in the cycle after the second CHECK, done asserted, toggles_done=1. err stays high until the next start.
- N=5, interval=2, abort held high starting in the GAP before the third pulse -> no third pulse, done next cycle, toggles_done=2, err=0. start asserted while busy has no effect.
- rst pulled low during PULSE -> t=0, busy=0 asynchronously. After release, a new start with N=1 completes normally.
